// File: rtl/fpga_input_ctrl.sv
// fpga_input_ctrl
// Board-input front end for the tile-matching game. It synchronises and
// debounces KEY[3:0] (active-low) and SW[9:0]. It produces clean levels,
// one-cycle press/release/change pulses and a quit pulse for the game FSM.
//
// Internal bit map of the 14-bit vectors:
//   [13:4] switches, 1 = up
//   [3:0]  keys,     1 = pressed (after the synchroniser)
module fpga_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int QUIT_KEY        = 3
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [3:0] key_held,
   output logic [3:0] key_press,
   output logic [3:0] key_release,
   output logic [9:0] sw_stable,
   output logic       sw_change,
   output logic       quit_pulse
);

   localparam int NB    = 14;
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   // KEY flops reset to the released level (1), switch flops reset to 0.
   localparam logic [NB-1:0]    SYNC_RST = {10'b0, 4'hF};

   logic [NB-1:0]    r_sync1;
   logic [NB-1:0]    r_sync2;
   logic [NB-1:0]    r_stable;
   logic [CNT_W-1:0] r_cnt [NB];

   logic [3:0]       r_key_held;
   logic [3:0]       r_key_press;
   logic [3:0]       r_key_release;
   logic [9:0]       r_sw_stable;
   logic             r_sw_change;
   logic             r_quit;

   logic [NB-1:0]    w_synced;
   logic [NB-1:0]    w_mismatch;

   // Keys are flipped to pressed = 1 only after the synchroniser.
   assign w_synced   = {r_sync2[13:4], ~r_sync2[3:0]};
   assign w_mismatch = w_synced ^ r_stable;

   // Two-flop synchroniser for every raw input bit.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= SYNC_RST;
         r_sync2 <= SYNC_RST;
      end else begin
         r_sync1 <= {SW, KEY};
         r_sync2 <= r_sync1;
      end
   end

   // Per-bit debounce. A new level is accepted only after it holds without
   // a break. Any return to the stable level clears the count.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_stable <= '0;
         for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (w_mismatch[i]) begin
               if (r_cnt[i] == CNT_TC) begin
                  r_stable[i] <= w_synced[i];
                  r_cnt[i]    <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + CNT_ONE;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // Registered levels and edge pulses. The held/stable registers also act
   // as the previous-state copy used for edge detection.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_key_held    <= '0;
         r_key_press   <= '0;
         r_key_release <= '0;
         r_sw_stable   <= '0;
         r_sw_change   <= 1'b0;
         r_quit        <= 1'b0;
      end else begin
         r_key_held    <= r_stable[3:0];
         r_key_press   <= r_stable[3:0] & ~r_key_held;
         r_key_release <= ~r_stable[3:0] & r_key_held;
         r_sw_stable   <= r_stable[13:4];
         r_sw_change   <= |(r_stable[13:4] ^ r_sw_stable);
         r_quit        <= r_stable[QUIT_KEY] & ~r_key_held[QUIT_KEY];
      end
   end

   assign key_held    = r_key_held;
   assign key_press   = r_key_press;
   assign key_release = r_key_release;
   assign sw_stable   = r_sw_stable;
   assign sw_change   = r_sw_change;
   assign quit_pulse  = r_quit;

endmodule

// File: tb/tb_fpga_input_ctrl.sv
// Directed bench for fpga_input_ctrl with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge, so the next rising edge is "edge 0".
// Outputs are sampled on the k-th following falling edge, which is after
// edge k-1. A pulse that is high after edge 6 is therefore seen at k = 7.
module tb_fpga_input_ctrl;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [3:0] key_held;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [9:0] sw_stable;
   logic       sw_change;
   logic       quit_pulse;

   int errors = 0;
   int checks = 0;

   fpga_input_ctrl #(.DEBOUNCE_CYCLES(4), .QUIT_KEY(3)) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .KEY         (KEY),
      .SW          (SW),
      .key_held    (key_held),
      .key_press   (key_press),
      .key_release (key_release),
      .sw_stable   (sw_stable),
      .sw_change   (sw_change),
      .quit_pulse  (quit_pulse)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " held"},    32'(key_held),    32'h0);
      chk({tag, " press"},   32'(key_press),   32'h0);
      chk({tag, " release"}, 32'(key_release), 32'h0);
      chk({tag, " sw"},      32'(sw_stable),   32'h0);
      chk({tag, " swchg"},   32'(sw_change),   32'h0);
      chk({tag, " quit"},    32'(quit_pulse),  32'h0);
   endtask

   logic [3:0] glitch_pat [12];

   initial begin
      // ---- 1: reset and idle ----
      resetn = 1'b0;
      KEY    = 4'hF;
      SW     = 10'h000;
      repeat (3) @(negedge CLOCK_50);
      chk_all_zero("rst");
      resetn = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLOCK_50);
         chk_all_zero($sformatf("idle%0d", k));
      end

      // ---- 2: KEY[0] press and hold ----
      KEY = 4'b1110;
      for (int k = 1; k <= 14; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("k0press%0d", k), 32'(key_press), (k == 7) ? 32'h1 : 32'h0);
         chk($sformatf("k0held%0d", k),  32'(key_held),  (k >= 7) ? 32'h1 : 32'h0);
         chk($sformatf("k0quit%0d", k),  32'(quit_pulse), 32'h0);
      end
      // Release KEY[0]. The release pulse follows the same latency.
      KEY = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("k0rel%0d", k),  32'(key_release), (k == 7) ? 32'h1 : 32'h0);
         chk($sformatf("k0held_r%0d", k), 32'(key_held), (k < 7) ? 32'h1 : 32'h0);
         chk($sformatf("k0press_r%0d", k), 32'(key_press), 32'h0);
      end

      // ---- 3: KEY[1] bounce, never 4 synced cycles in a row ----
      glitch_pat = '{4'hD, 4'hD, 4'hF, 4'hD, 4'hD, 4'hF,
                     4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      for (int k = 0; k < 12; k++) begin
         KEY = glitch_pat[k];
         @(negedge CLOCK_50);
         chk($sformatf("glpress%0d", k), 32'(key_press),   32'h0);
         chk($sformatf("glheld%0d", k),  32'(key_held),    32'h0);
         chk($sformatf("glrel%0d", k),   32'(key_release), 32'h0);
      end
      KEY = 4'hF;
      repeat (4) @(negedge CLOCK_50);

      // ---- 4: KEY[3] press for 10 cycles, then release ----
      KEY = 4'b0111;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("k3press%0d", k), 32'(key_press),  (k == 7) ? 32'h8 : 32'h0);
         chk($sformatf("k3quit%0d", k),  32'(quit_pulse), (k == 7) ? 32'h1 : 32'h0);
      end
      KEY = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("k3rel%0d", k),   32'(key_release), (k == 7) ? 32'h8 : 32'h0);
         chk($sformatf("k3held%0d", k),  32'(key_held),    (k < 7) ? 32'h8 : 32'h0);
         chk($sformatf("k3quit_r%0d", k), 32'(quit_pulse), 32'h0);
         chk($sformatf("k3press_r%0d", k), 32'(key_press), 32'h0);
      end

      // ---- 5: SW 000 -> 201 in one step ----
      SW = 10'h201;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("swchg%0d", k), 32'(sw_change), (k == 7) ? 32'h1 : 32'h0);
         chk($sformatf("swst%0d", k),  32'(sw_stable), (k >= 7) ? 32'h201 : 32'h0);
      end

      // ---- 6: reset in the middle of a KEY[2] count ----
      KEY = 4'b1011;
      repeat (3) @(negedge CLOCK_50);
      chk("k2_mid_nopress", 32'(key_press), 32'h0);
      resetn = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLOCK_50);
         chk_all_zero($sformatf("rst2_%0d", k));
      end
      resetn = 1'b1;
      // KEY[2] and the switches are still active, so both are treated as new.
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("k2press%0d", k), 32'(key_press), (k == 7) ? 32'h4 : 32'h0);
         chk($sformatf("k2held%0d", k),  32'(key_held),  (k >= 7) ? 32'h4 : 32'h0);
         chk($sformatf("rsw_chg%0d", k), 32'(sw_change), (k == 7) ? 32'h1 : 32'h0);
         chk($sformatf("rsw_st%0d", k),  32'(sw_stable), (k >= 7) ? 32'h201 : 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
